calc_accum_seq: RTL and testbench
=================================

// Module: calc_accum_seq
// PURPOSE
//  Parametrised chained-accumulator calculator for the board lab designs; sits between the
//  switch/button inputs and the hex display driver. Debounces the button internally, runs
//  add/sub/mul/div/mod/square/clear on num1/num2 or on the running result, and uses a
//  multi-cycle divider. It reports busy/done status and a divide-by-zero error.
// PARAMETERS
//  OPW          8        operand width (num1, num2)
//  ACCW         32       accumulator / cal_result width; ACCW >= 2*OPW
//  DBNC_CYCLES  1000000  consecutive stable samples required to accept a button level (>=1)
// PORTS
//  clk         in   1     system clock, all logic on posedge
//  rst_n       in   1     synchronous reset, active-low
//  button      in   1     raw, asynchronous, bouncy "execute" button
//  func        in   3     operation select, sampled on trigger
//  num1        in   OPW   first operand (used only when chain empty)
//  num2        in   OPW   second operand
//  cal_result  out  ACCW  accumulator value
//  busy        out  1     high while an operation is in flight
//  done        out  1     1-cycle pulse when cal_result (or err_div0) updates
//  err_div0    out  1     sticky divide/modulo-by-zero flag
//  chained     out  1     0 = next op uses num1, 1 = next op uses cal_result
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): cal_result=0, busy=0, done=0, err_div0=0, chained=0, FSM=IDLE,
//   sync flops=0, debounced level=0, debounce counter=0. Reset mid-division aborts it.
//  Button path: 2-flop synchroniser -> counter; debounced level takes synced value after
//   DBNC_CYCLES consecutive cycles differing from current level; any mismatch-free break restarts count.
//   trig = 1-cycle pulse on debounced 0->1. Release edge does nothing.
//  Operand A = chained ? cal_result : zero-extend(num1); B = zero-extend(num2). func/num sampled at trig.
//  func: 000 A+B | 001 A-B | 010 A*B | 011 A/B | 100 A%B | 101 A*A | 110 clear | 111 no-op.
//  Arithmetic unsigned, results truncated mod 2^ACCW (sub wraps two's complement; A*A keeps low ACCW bits).
//  FSM: IDLE, DIV, DONE.
//   IDLE, trig, func in {000,001,010,101}: result written at next edge, chained<=1, err_div0<=0,
//    done=1 that same cycle (latency 1 from trig); stay IDLE. busy stays 0.
//   IDLE, trig, func=110: cal_result<=0, chained<=0, err_div0<=0, done pulse, latency 1.
//   IDLE, trig, func=111: no state change, no done.
//   IDLE, trig, func in {011,100}, B==0: cal_result and chained unchanged, err_div0<=1, done pulse.
//   IDLE, trig, func in {011,100}, B!=0: start divider, busy<=1 -> DIV.
//   DIV: wait for divider valid (exactly ACCW cycles after start); then write quotient or
//    remainder, chained<=1, err_div0<=0, busy<=0 -> DONE. DONE: done=1 one cycle -> IDLE.
//   Div latency: result visible ACCW+1 cycles after trig, done coincident.
//  trig while busy=1 is discarded (not queued). trig coinciding with reset: reset wins.
//  done never asserts in the same cycle as reset or for func=111.
// STRUCTURE
//  Package calc_pkg: func enum (OP_ADD..OP_NOP, 3 bits), FSM state enum, default widths.
//  Sub-module calc_seq_div: restoring radix-2 unsigned divider, ACCW dividend / ACCW divisor,
//   ports start, dividend, divisor, busy, valid (1-cycle), quotient, remainder; ACCW iterations.
//  Debouncer kept inline (one counter of clog2(DBNC_CYCLES+1) bits).
// TESTING (bench uses DBNC_CYCLES=4, OPW=8, ACCW=32)
//  Press, func=000, num1=0x12, num2=0x34 -> cal_result=0x46, done 1 pulse, chained=1, busy never 1.
//  Chain: then func=010 num2=0x10 -> 0x460; func=101 -> 0x132400; func=001 num2=0xFF from 0x132400 -> 0x132301.
//  From cal_result=0x00000005, func=001 num2=0x07 -> 0xFFFFFFFE (wrap); func=110 -> 0, chained=0.
//  func=011 num1=200 num2=7 (chain empty) -> busy 32 cycles, cal_result=28 at done;
//   then func=100 num2=5 -> 3; second press during busy ignored (result still 3, single done).
//  func=011 num2=0 with cal_result=0x46 -> err_div0=1, cal_result=0x46, done pulse; next add clears err.
//  Bounce: toggle button every 2 cycles for 20 cycles then hold 1 -> exactly one trig/done;
//   rst_n=0 mid-DIV -> all outputs zero next cycle, no done afterwards.

Source files
------------

// File: rtl/calc_pkg.sv
// Shared types and default widths for the chained accumulator calculator.
package calc_pkg;

  localparam int OPW_DEF  = 8;
  localparam int ACCW_DEF = 32;
  localparam int DBNC_DEF = 1000000;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_DIV = 3'b011,
    OP_MOD = 3'b100,
    OP_SQR = 3'b101,
    OP_CLR = 3'b110,
    OP_NOP = 3'b111
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DIV,
    S_DONE
  } state_e;

endpackage

// File: rtl/calc_seq_div.sv
// Restoring radix-2 unsigned divider, one quotient bit per cycle.
module calc_seq_div #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         valid,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  rem_q;
  logic [W-1:0]  quo_q;
  logic [W-1:0]  dsr_q;
  logic [CW-1:0] cnt;

  function automatic logic [2*W-1:0] step(
    input logic [W-1:0] r,
    input logic [W-1:0] q,
    input logic [W-1:0] d
  );
    logic [W:0] t;
    t = {r, q[W-1]};
    if (t >= {1'b0, d}) begin
      t = t - {1'b0, d};
      return {t[W-1:0], q[W-2:0], 1'b1};
    end
    return {t[W-1:0], q[W-2:0], 1'b0};
  endfunction

  // First iteration happens on the start edge so valid lands W cycles later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
      cnt   <= '0;
      valid <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (start) begin
        {rem_q, quo_q} <= step('0, dividend, divisor);
        dsr_q          <= divisor;
        cnt            <= CW'(W - 1);
      end else if (cnt != '0) begin
        {rem_q, quo_q} <= step(rem_q, quo_q, dsr_q);
        cnt            <= cnt - CW'(1);
        if (cnt == CW'(1)) valid <= 1'b1;
      end
    end
  end

  assign busy      = (cnt != '0);
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/calc_accum_seq.sv
// Chained accumulator calculator: debounced execute button, ALU and
// multi-cycle divider with busy/done/divide-by-zero status.
module calc_accum_seq
  import calc_pkg::*;
#(
  parameter int OPW         = OPW_DEF,
  parameter int ACCW        = ACCW_DEF,
  parameter int DBNC_CYCLES = DBNC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            button,
  input  logic [2:0]      func,
  input  logic [OPW-1:0]  num1,
  input  logic [OPW-1:0]  num2,
  output logic [ACCW-1:0] cal_result,
  output logic            busy,
  output logic            done,
  output logic            err_div0,
  output logic            chained
);

  localparam int CW = $clog2(DBNC_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          trig;
  logic [CW-1:0] dcnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      trig  <= 1'b0;
      dcnt  <= '0;
    end else begin
      sync1 <= button;
      sync2 <= sync1;
      trig  <= 1'b0;
      if (sync2 != level) begin
        if (dcnt == CW'(DBNC_CYCLES - 1)) begin
          level <= sync2;
          dcnt  <= '0;
          trig  <= sync2;
        end else begin
          dcnt <= dcnt + CW'(1);
        end
      end else begin
        dcnt <= '0;
      end
    end
  end

  func_e           op;
  state_e          state;
  logic [ACCW-1:0] op_a;
  logic [ACCW-1:0] op_b;
  logic [ACCW-1:0] alu_res;
  logic            b_zero;
  logic            is_mod;
  logic            div_start;
  logic            div_busy;
  logic            div_valid;
  logic [ACCW-1:0] div_quo;
  logic [ACCW-1:0] div_rem;

  assign op     = func_e'(func);
  assign op_a   = chained ? cal_result : ACCW'(num1);
  assign op_b   = ACCW'(num2);
  assign b_zero = (op_b == '0);

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = op_a + op_b;
      OP_SUB:  alu_res = op_a - op_b;
      OP_MUL:  alu_res = op_a * op_b;
      OP_SQR:  alu_res = op_a * op_a;
      default: alu_res = '0;
    endcase
  end

  assign div_start = (state == S_IDLE) && trig && !div_busy
                   && (op == OP_DIV || op == OP_MOD) && !b_zero;

  calc_seq_div #(.W(ACCW)) u_div (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (div_start),
    .dividend  (op_a),
    .divisor   (op_b),
    .busy      (div_busy),
    .valid     (div_valid),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cal_result <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      err_div0   <= 1'b0;
      chained    <= 1'b0;
      is_mod     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (trig && !div_busy) begin
            unique case (op)
              OP_ADD, OP_SUB, OP_MUL, OP_SQR: begin
                cal_result <= alu_res;
                chained    <= 1'b1;
                err_div0   <= 1'b0;
                done       <= 1'b1;
              end
              OP_CLR: begin
                cal_result <= '0;
                chained    <= 1'b0;
                err_div0   <= 1'b0;
                done       <= 1'b1;
              end
              OP_DIV, OP_MOD: begin
                if (b_zero) begin
                  err_div0 <= 1'b1;
                  done     <= 1'b1;
                end else begin
                  busy   <= 1'b1;
                  is_mod <= (op == OP_MOD);
                  state  <= S_DIV;
                end
              end
              OP_NOP: ;
            endcase
          end
        end
        S_DIV: begin
          if (div_valid) begin
            cal_result <= is_mod ? div_rem : div_quo;
            chained    <= 1'b1;
            err_div0   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_calc_accum_seq.sv
// Self-checking bench for calc_accum_seq: directed scenarios plus random
// operations compared against an arithmetic reference model.
module tb_calc_accum_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        button;
  logic [2:0]  func;
  logic [7:0]  num1;
  logic [7:0]  num2;
  logic [31:0] cal_result;
  logic        busy;
  logic        done;
  logic        err_div0;
  logic        chained;

  int checks = 0;
  int fails  = 0;

  // observations from the last operation
  int          o_done;
  int          o_busy;
  logic [31:0] o_res;

  // reference model state
  logic [31:0] m_acc;
  logic        m_chain;
  logic        m_err;
  int          exp_done;
  int          exp_busy;

  calc_accum_seq #(.OPW(8), .ACCW(32), .DBNC_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .button     (button),
    .func       (func),
    .num1       (num1),
    .num2       (num2),
    .cal_result (cal_result),
    .busy       (busy),
    .done       (done),
    .err_div0   (err_div0),
    .chained    (chained)
  );

  always #5 clk = ~clk;

  function automatic void model_exec(input logic [2:0] f,
                                     input logic [7:0] n1,
                                     input logic [7:0] n2);
    logic [31:0] a;
    logic [31:0] b;
    a = m_chain ? m_acc : {24'd0, n1};
    b = {24'd0, n2};
    exp_done = 1;
    exp_busy = 0;
    case (f)
      3'd0: begin m_acc = a + b; m_chain = 1; m_err = 0; end
      3'd1: begin m_acc = a - b; m_chain = 1; m_err = 0; end
      3'd2: begin m_acc = a * b; m_chain = 1; m_err = 0; end
      3'd5: begin m_acc = a * a; m_chain = 1; m_err = 0; end
      3'd6: begin m_acc = 0; m_chain = 0; m_err = 0; end
      3'd3, 3'd4: begin
        if (b == 0) m_err = 1;
        else begin
          m_acc = (f == 3'd3) ? a / b : a % b;
          m_chain = 1;
          m_err = 0;
          exp_busy = 32;
        end
      end
      default: exp_done = 0;
    endcase
  endfunction

  task automatic mon(input int n);
    repeat (n) begin
      @(negedge clk);
      if (done) begin
        o_done++;
        o_res = cal_result;
      end
      if (busy) o_busy++;
    end
  endtask

  task automatic run_op(input logic [2:0] f,
                        input logic [7:0] n1,
                        input logic [7:0] n2);
    func   = f;
    num1   = n1;
    num2   = n2;
    o_done = 0;
    o_busy = 0;
    o_res  = 'x;
    button = 1'b1;
    mon(60);
    button = 1'b0;
    mon(15);
  endtask

  task automatic test_reset;
    rst_n  = 1'b0;
    button = 1'b0;
    func   = 3'd0;
    num1   = 8'd0;
    num2   = 8'd0;
    repeat (3) @(negedge clk);
    checks++;
    if (cal_result !== 32'd0) begin
      fails++;
      $display("FAIL reset_result got %h want 0", cal_result);
    end
    checks++;
    if ({busy, done, err_div0, chained} !== 4'b0) begin
      fails++;
      $display("FAIL reset_flags got %b want 0000",
               {busy, done, err_div0, chained});
    end
    rst_n   = 1'b1;
    m_acc   = 0;
    m_chain = 0;
    m_err   = 0;
    @(negedge clk);
  endtask

  task automatic test_add;
    run_op(3'd0, 8'h12, 8'h34);
    model_exec(3'd0, 8'h12, 8'h34);
    checks++;
    if (o_res !== 32'h46 || o_done !== 1) begin
      fails++;
      $display("FAIL add got %h dones %0d want 46 dones 1", o_res, o_done);
    end
    checks++;
    if (o_busy !== 0 || chained !== 1'b1) begin
      fails++;
      $display("FAIL add_status busy %0d chained %b want 0 1",
               o_busy, chained);
    end
  endtask

  task automatic test_chain;
    logic [2:0]  fs [3];
    logic [7:0]  ns [3];
    logic [31:0] ex [3];
    fs = '{3'd2, 3'd5, 3'd1};
    ns = '{8'h10, 8'h00, 8'hFF};
    ex = '{32'h460, 32'h132400, 32'h132301};
    for (int i = 0; i < 3; i++) begin
      run_op(fs[i], 8'h00, ns[i]);
      model_exec(fs[i], 8'h00, ns[i]);
      checks++;
      if (o_res !== ex[i] || o_done !== 1 || o_busy !== 0) begin
        fails++;
        $display("FAIL chain%0d got %h dones %0d busy %0d want %h 1 0",
                 i, o_res, o_done, o_busy, ex[i]);
      end
    end
  endtask

  task automatic test_wrap;
    run_op(3'd6, 8'h0, 8'h0);
    model_exec(3'd6, 8'h0, 8'h0);
    run_op(3'd0, 8'h05, 8'h00);
    model_exec(3'd0, 8'h05, 8'h00);
    run_op(3'd1, 8'h00, 8'h07);
    model_exec(3'd1, 8'h00, 8'h07);
    checks++;
    if (o_res !== 32'hFFFFFFFE) begin
      fails++;
      $display("FAIL sub_wrap got %h want fffffffe", o_res);
    end
    run_op(3'd6, 8'h00, 8'h00);
    model_exec(3'd6, 8'h00, 8'h00);
    checks++;
    if (cal_result !== 32'd0 || chained !== 1'b0 || o_done !== 1) begin
      fails++;
      $display("FAIL clear got %h chained %b dones %0d want 0 0 1",
               cal_result, chained, o_done);
    end
  endtask

  task automatic test_div;
    int guard;
    run_op(3'd3, 8'd200, 8'd7);
    model_exec(3'd3, 8'd200, 8'd7);
    checks++;
    if (o_res !== 32'd28 || o_busy !== 32 || o_done !== 1) begin
      fails++;
      $display("FAIL div got %0d busy %0d dones %0d want 28 32 1",
               o_res, o_busy, o_done);
    end
    // modulo with a second press landing while busy
    func   = 3'd4;
    num1   = 8'd0;
    num2   = 8'd5;
    o_done = 0;
    o_busy = 0;
    button = 1'b1;
    guard  = 0;
    while (!busy && guard < 30) begin
      mon(1);
      guard++;
    end
    checks++;
    if (!busy) begin
      fails++;
      $display("FAIL mod_start busy %b want 1", busy);
    end
    button = 1'b0;
    mon(8);
    button = 1'b1;
    mon(10);
    button = 1'b0;
    mon(40);
    model_exec(3'd4, 8'd0, 8'd5);
    checks++;
    if (cal_result !== 32'd3 || o_done !== 1) begin
      fails++;
      $display("FAIL mod_ignore got %0d dones %0d want 3 1",
               cal_result, o_done);
    end
  endtask

  task automatic test_div0;
    run_op(3'd6, 8'd0, 8'd0);
    model_exec(3'd6, 8'd0, 8'd0);
    run_op(3'd0, 8'h12, 8'h34);
    model_exec(3'd0, 8'h12, 8'h34);
    run_op(3'd3, 8'd0, 8'd0);
    model_exec(3'd3, 8'd0, 8'd0);
    checks++;
    if (err_div0 !== 1'b1 || cal_result !== 32'h46 || o_done !== 1) begin
      fails++;
      $display("FAIL div0 err %b got %h dones %0d want 1 46 1",
               err_div0, cal_result, o_done);
    end
    run_op(3'd0, 8'd0, 8'd1);
    model_exec(3'd0, 8'd0, 8'd1);
    checks++;
    if (err_div0 !== 1'b0 || cal_result !== 32'h47) begin
      fails++;
      $display("FAIL div0_clear err %b got %h want 0 47",
               err_div0, cal_result);
    end
  endtask

  task automatic test_bounce;
    func   = 3'd0;
    num1   = 8'd0;
    num2   = 8'h11;
    o_done = 0;
    o_busy = 0;
    for (int i = 0; i < 10; i++) begin
      button = ~button;
      mon(2);
    end
    button = 1'b1;
    mon(40);
    button = 1'b0;
    mon(15);
    model_exec(3'd0, 8'd0, 8'h11);
    checks++;
    if (o_done !== 1 || cal_result !== m_acc) begin
      fails++;
      $display("FAIL bounce dones %0d got %h want 1 %h",
               o_done, cal_result, m_acc);
    end
  endtask

  task automatic test_random;
    logic [2:0] f;
    logic [7:0] a;
    logic [7:0] b;
    for (int i = 0; i < 24; i++) begin
      f = 3'($urandom_range(0, 7));
      a = 8'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
      run_op(f, a, b);
      model_exec(f, a, b);
      checks++;
      if (cal_result !== m_acc || err_div0 !== m_err ||
          chained !== m_chain || o_done !== exp_done ||
          o_busy !== exp_busy) begin
        fails++;
        $display("FAIL rand%0d f=%0d got %h/%b/%b/%0d/%0d want %h/%b/%b/%0d/%0d",
                 i, f, cal_result, err_div0, chained, o_done, o_busy,
                 m_acc, m_err, m_chain, exp_done, exp_busy);
      end
    end
  endtask

  task automatic test_reset_mid_div;
    int guard;
    run_op(3'd6, 8'd0, 8'd0);
    model_exec(3'd6, 8'd0, 8'd0);
    func   = 3'd3;
    num1   = 8'd250;
    num2   = 8'd3;
    button = 1'b1;
    guard  = 0;
    while (!busy && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (!busy) begin
      fails++;
      $display("FAIL rst_div_start busy %b want 1", busy);
    end
    repeat (5) @(negedge clk);
    rst_n  = 1'b0;
    button = 1'b0;
    @(negedge clk);
    checks++;
    if (cal_result !== 32'd0 ||
        {busy, done, err_div0, chained} !== 4'b0) begin
      fails++;
      $display("FAIL rst_mid_div got %h %b want 0 0000",
               cal_result, {busy, done, err_div0, chained});
    end
    rst_n  = 1'b1;
    o_done = 0;
    o_busy = 0;
    mon(50);
    checks++;
    if (o_done !== 0 || o_busy !== 0) begin
      fails++;
      $display("FAIL rst_no_done dones %0d busy %0d want 0 0",
               o_done, o_busy);
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_chain;
    test_wrap;
    test_div;
    test_div0;
    test_bounce;
    test_random;
    test_reset_mid_div;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
